// File: rtl/gpio_bridge_sync.sv
// Clocked GPIO fan-out into per-channel ctrl/din/dout_en groups, with
// synchronised dout readback and ack-cleared sticky change flags.
module gpio_bridge_sync #(
  parameter int NUM_CH      = 4,
  parameter int CTRL_W      = 6,
  parameter int GPIO_W      = 32,
  parameter int MODE        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [GPIO_W-1:0]        gpio_in,
  input  logic                     commit,
  input  logic                     ack,
  input  logic [NUM_CH-1:0]        dout_i,
  output logic [NUM_CH*CTRL_W-1:0] ctrl_o,
  output logic [NUM_CH-1:0]        din_o,
  output logic [NUM_CH-1:0]        dout_en_o,
  output logic [NUM_CH-1:0]        upd_o,
  output logic [GPIO_W-1:0]        gpio_out
);

  localparam int F    = CTRL_W + 2;
  localparam int MAPW = NUM_CH * F;
  localparam int WCW  = $clog2(SYNC_STAGES + 2);
  localparam logic [WCW-1:0] WARM_MAX = WCW'(SYNC_STAGES + 1);

  logic [MAPW-1:0]                       gpio_q, gpio_d;
  logic                                  commit_q, commit_q2;
  logic                                  ack_q, ack_q2;
  logic [NUM_CH*CTRL_W-1:0]              ctrl_q, ctrl_d;
  logic [NUM_CH-1:0]                     din_q, din_d;
  logic [NUM_CH-1:0]                     en_q, en_d;
  logic [NUM_CH-1:0]                     upd_q, upd_d;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0]    sync_q, sync_d;
  logic [NUM_CH-1:0]                     dout_s;
  logic [NUM_CH-1:0]                     dout_p_q;
  logic [NUM_CH-1:0]                     chg_q, chg_d;
  logic [WCW-1:0]                        warm_q, warm_d;
  logic [GPIO_W-1:0]                     gout_q, gout_d;
  logic                                  commit_edge, ack_edge, load;
  logic [F-1:0]                          fld;

  assign dout_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    gpio_d      = gpio_in[MAPW-1:0];
    commit_edge = commit_q & ~commit_q2;
    ack_edge    = ack_q & ~ack_q2;
    load        = (MODE == 0) ? 1'b1 : commit_edge;
    ctrl_d      = ctrl_q;
    din_d       = din_q;
    en_d        = en_q;
    upd_d       = '0;
    fld         = '0;
    if (load) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        fld = gpio_q[k*F +: F];
        // Pulse only for channels whose loaded field actually differs
        upd_d[k] = (fld != {en_q[k], din_q[k], ctrl_q[k*CTRL_W +: CTRL_W]});
        ctrl_d[k*CTRL_W +: CTRL_W] = fld[CTRL_W-1:0];
        din_d[k] = fld[CTRL_W];
        en_d[k]  = fld[CTRL_W+1];
      end
    end

    sync_d = {sync_q[SYNC_STAGES-2:0], dout_i};
    warm_d = (warm_q == WARM_MAX) ? warm_q : warm_q + 1'b1;
    // Set is OR'd in after the clear so a coincident change is not lost
    chg_d  = (chg_q & ~{NUM_CH{ack_edge}})
           | ((warm_q == WARM_MAX) ? (dout_s ^ dout_p_q) : '0);

    gout_d = '0;
    gout_d[NUM_CH-1:0]        = dout_s;
    gout_d[2*NUM_CH-1:NUM_CH] = chg_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_q    <= '0;
      commit_q  <= 1'b0;
      commit_q2 <= 1'b0;
      ack_q     <= 1'b0;
      ack_q2    <= 1'b0;
      ctrl_q    <= '0;
      din_q     <= '0;
      en_q      <= '0;
      upd_q     <= '0;
      sync_q    <= '0;
      dout_p_q  <= '0;
      chg_q     <= '0;
      warm_q    <= '0;
      gout_q    <= '0;
    end else begin
      gpio_q    <= gpio_d;
      commit_q  <= commit;
      commit_q2 <= commit_q;
      ack_q     <= ack;
      ack_q2    <= ack_q;
      ctrl_q    <= ctrl_d;
      din_q     <= din_d;
      en_q      <= en_d;
      upd_q     <= upd_d;
      sync_q    <= sync_d;
      dout_p_q  <= dout_s;
      chg_q     <= chg_d;
      warm_q    <= warm_d;
      gout_q    <= gout_d;
    end
  end

  assign ctrl_o    = ctrl_q;
  assign din_o     = din_q;
  assign dout_en_o = en_q;
  assign upd_o     = upd_q;
  assign gpio_out  = gout_q;

endmodule

// File: tb/tb_gpio_bridge_sync.sv
// Bench for gpio_bridge_sync: MODE=0 and MODE=1 instances share stimulus and
// are compared each cycle against a queue/arithmetic reference model.
module tb_gpio_bridge_sync;

  localparam int NC = 4;
  localparam int CW = 6;
  localparam int GW = 32;
  localparam int SS = 2;
  localparam int F  = CW + 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [GW-1:0]     gpio_in;
  logic              commit, ack;
  logic [NC-1:0]     dout_i;
  logic [NC*CW-1:0]  ctrl0, ctrl1;
  logic [NC-1:0]     din0, din1, en0, en1, upd0, upd1;
  logic [GW-1:0]     gout0, gout1;

  always #5 clk = ~clk;

  gpio_bridge_sync #(.NUM_CH(NC), .CTRL_W(CW), .GPIO_W(GW), .MODE(0), .SYNC_STAGES(SS)) dut0 (
    .clk(clk), .rst_n(rst_n), .gpio_in(gpio_in), .commit(commit), .ack(ack), .dout_i(dout_i),
    .ctrl_o(ctrl0), .din_o(din0), .dout_en_o(en0), .upd_o(upd0), .gpio_out(gout0));

  gpio_bridge_sync #(.NUM_CH(NC), .CTRL_W(CW), .GPIO_W(GW), .MODE(1), .SYNC_STAGES(SS)) dut1 (
    .clk(clk), .rst_n(rst_n), .gpio_in(gpio_in), .commit(commit), .ack(ack), .dout_i(dout_i),
    .ctrl_o(ctrl1), .din_o(din1), .dout_en_o(en1), .upd_o(upd1), .gpio_out(gout1));

  int total = 0;
  int bad   = 0;

  // Reference model: inputs seen at past edges, outputs as plain field arithmetic
  logic [GW-1:0]    m_gq;
  logic             m_c1, m_c2, m_a1, m_a2;
  logic [NC-1:0]    m_q[$];
  logic [NC-1:0]    m_p, m_chg;
  int               m_cyc;
  logic [NC*CW-1:0] e_ctrl[2];
  logic [NC-1:0]    e_din[2], e_en[2], e_upd[2];
  logic [GW-1:0]    e_gout;

  task automatic model_reset();
    m_gq = '0; m_c1 = 0; m_c2 = 0; m_a1 = 0; m_a2 = 0;
    m_p = '0; m_chg = '0; m_cyc = 0; e_gout = '0;
    m_q.delete();
    for (int i = 0; i < SS; i++) m_q.push_back('0);
    for (int m = 0; m < 2; m++) begin
      e_ctrl[m] = '0; e_din[m] = '0; e_en[m] = '0; e_upd[m] = '0;
    end
  endtask

  task automatic model_edge();
    logic [NC-1:0] ds, nchg, dummy;
    logic [F-1:0]  oldf, newf;
    bit            ld;
    ds = m_q[0];
    for (int m = 0; m < 2; m++) begin
      ld = (m == 0) || (m_c1 && !m_c2);
      for (int k = 0; k < NC; k++) begin
        oldf = {e_en[m][k], e_din[m][k], e_ctrl[m][k*CW +: CW]};
        newf = ld ? F'((m_gq >> (k*F)) & ((1 << F) - 1)) : oldf;
        e_upd[m][k] = (newf != oldf);
        e_ctrl[m][k*CW +: CW] = newf[CW-1:0];
        e_din[m][k] = newf[CW];
        e_en[m][k]  = newf[CW+1];
      end
    end
    nchg = m_chg;
    if (m_a1 && !m_a2) nchg = '0;
    if (m_cyc >= SS + 1) nchg = nchg | (ds ^ m_p);
    e_gout = '0;
    e_gout[NC-1:0] = ds;
    e_gout[2*NC-1:NC] = m_chg;
    m_chg = nchg;
    m_p = ds;
    m_q.push_back(dout_i);
    dummy = m_q.pop_front();
    m_gq = gpio_in;
    m_c2 = m_c1; m_c1 = commit;
    m_a2 = m_a1; m_a1 = ack;
    if (m_cyc < SS + 1) m_cyc++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("m0_ctrl", 64'(ctrl0), 64'(e_ctrl[0]));
    chk("m0_din",  64'(din0),  64'(e_din[0]));
    chk("m0_en",   64'(en0),   64'(e_en[0]));
    chk("m0_upd",  64'(upd0),  64'(e_upd[0]));
    chk("m0_gout", 64'(gout0), 64'(e_gout));
    chk("m1_ctrl", 64'(ctrl1), 64'(e_ctrl[1]));
    chk("m1_din",  64'(din1),  64'(e_din[1]));
    chk("m1_en",   64'(en1),   64'(e_en[1]));
    chk("m1_upd",  64'(upd1),  64'(e_upd[1]));
    chk("m1_gout", 64'(gout1), 64'(e_gout));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [GW-1:0]    w;
    logic [NC*CW-1:0] ctrl;
    logic [NC-1:0]    din, en, upd;
  } vec_t;
  vec_t tbl[5];

  initial begin
    rst_n = 1'b0; gpio_in = '0; commit = 0; ack = 0; dout_i = '0;
    model_reset();

    tbl[0] = '{32'hE3224321, {6'h23, 6'h22, 6'h03, 6'h21}, 4'b1010, 4'b1000, 4'b1111};
    tbl[1] = '{32'hE3224321, {6'h23, 6'h22, 6'h03, 6'h21}, 4'b1010, 4'b1000, 4'b0000};
    tbl[2] = '{32'h00000000, {6'h00, 6'h00, 6'h00, 6'h00}, 4'b0000, 4'b0000, 4'b1111};
    tbl[3] = '{32'hFFFFFFFF, {6'h3F, 6'h3F, 6'h3F, 6'h3F}, 4'b1111, 4'b1111, 4'b1111};
    tbl[4] = '{32'hFF0000FF, {6'h3F, 6'h00, 6'h00, 6'h3F}, 4'b1001, 4'b1001, 4'b0110};

    // Reset state
    do_reset();
    step();
    chk("rst_ctrl0", 64'(ctrl0), 64'h0);
    chk("rst_gout0", 64'(gout0), 64'h0);
    chk("rst_upd1",  64'(upd1),  64'h0);

    // MODE=0 table: two-cycle latency, pulse only on change
    foreach (tbl[i]) begin
      gpio_in = tbl[i].w;
      step(); step();
      chk("tbl_ctrl", 64'(ctrl0), 64'(tbl[i].ctrl));
      chk("tbl_din",  64'(din0),  64'(tbl[i].din));
      chk("tbl_en",   64'(en0),   64'(tbl[i].en));
      chk("tbl_upd",  64'(upd0),  64'(tbl[i].upd));
      step();
      chk("tbl_upd_clr", 64'(upd0), 64'h0);
    end

    // MODE=1: no load without a commit edge, then exactly one load
    do_reset();
    gpio_in = 32'h000000FF;
    repeat (10) step();
    chk("m1_hold_ctrl", 64'(ctrl1), 64'h0);
    chk("m1_hold_en",   64'(en1),   64'h0);
    commit = 1;
    step(); step();
    chk("m1_commit_ctrl", 64'(ctrl1), 64'h3F);
    chk("m1_commit_din",  64'(din1),  64'h1);
    chk("m1_commit_en",   64'(en1),   64'h1);
    chk("m1_commit_upd",  64'(upd1),  64'h1);
    gpio_in = 32'h0000FF00;
    repeat (5) step();
    chk("m1_held_ctrl", 64'(ctrl1), 64'h3F);
    chk("m1_held_upd",  64'(upd1),  64'h0);
    commit = 0; step();
    commit = 1; step(); step();
    chk("m1_recommit_ctrl", 64'(ctrl1), {40'h0, 6'h0, 6'h0, 6'h3F, 6'h0});
    chk("m1_recommit_upd",  64'(upd1),  64'h3);
    commit = 0;

    // Sync and sticky flag with ack
    do_reset();
    repeat (5) step();
    dout_i[2] = 1'b1;
    repeat (SS + 1) step();
    chk("sync_bit_only", 64'(gout0), 64'h04);
    step();
    chk("sync_flag", 64'(gout0), 64'h44);
    ack = 1;
    repeat (3) step();
    chk("ack_clear", 64'(gout0), 64'h04);
    ack = 0;
    step();

    // Set and clear in the same cycle: set wins
    dout_i[1] = 1'b1;
    repeat (SS - 1) step();
    ack = 1;
    repeat (4) step();
    chk("set_wins", 64'(gout0), 64'h26);
    ack = 0;
    step();

    // Warm-up masks reset-time dout levels
    dout_i = 4'hF;
    do_reset();
    repeat (10) step();
    chk("warmup", 64'(gout0), 64'h0F);
    dout_i = '0;

    // Reset mid-operation, commit still high through release
    do_reset();
    gpio_in = 32'h12345678;
    repeat (3) step();
    commit = 1;
    step();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_ctrl0", 64'(ctrl0), 64'h0);
    chk("midrst_ctrl1", 64'(ctrl1), 64'h0);
    chk("midrst_upd0",  64'(upd0),  64'h0);
    step(); step();
    chk("midrst_upd1",  64'(upd1),  64'h0);
    rst_n = 1'b1;
    step(); step();
    chk("rel_ctrl1", 64'(ctrl1), 64'(24'({6'h12, 6'h34, 6'h16, 6'h38})));
    chk("rel_din1",  64'(din1),  64'h3);
    chk("rel_en1",   64'(en1),   64'h0);
    chk("rel_upd1",  64'(upd1),  64'hF);
    step();
    chk("rel_once",  64'(upd1),  64'h0);
    commit = 0;

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) == 0) gpio_in = $urandom();
      if ($urandom_range(0, 3) == 0) commit = ~commit;
      if ($urandom_range(0, 4) == 0) ack = ~ack;
      for (int b = 0; b < NC; b++)
        if ($urandom_range(0, 7) == 0) dout_i[b] = ~dout_i[b];
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
